// File: rtl/led_sopc_nios2_qsys_oci_dct_packer_if.sv
// Atom-input and packed-word-output handshakes of the OCI trace atom packer.
interface led_sopc_nios2_qsys_oci_dct_packer_if;
    localparam int unsigned WORD_W = 34;

    logic              atom_valid;
    logic [1:0]        atom;
    logic              atom_ready;
    logic              flush;
    logic              end_req;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_word;

    modport master (
        output atom_valid,
        output atom,
        output flush,
        output end_req,
        output out_ready,
        input  atom_ready,
        input  out_valid,
        input  out_word
    );

    modport slave (
        input  atom_valid,
        input  atom,
        input  flush,
        input  end_req,
        input  out_ready,
        output atom_ready,
        output out_valid,
        output out_word
    );
endinterface

// File: rtl/led_sopc_nios2_qsys_oci_dct_packer.sv
// Packs 2-bit trace atoms into 30-bit words, hands them to the trace sink and
// sequences the end-of-test drain for the OCI test-bench monitor.
module led_sopc_nios2_qsys_oci_dct_packer #(
    parameter int unsigned ATOMS_PER_WORD = 15,
    parameter int unsigned DROP_CNT_W     = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    led_sopc_nios2_qsys_oci_dct_packer_if.slave bus,
    output logic [2*ATOMS_PER_WORD-1:0]   dct_buffer,
    output logic [3:0]                    dct_count,
    output logic                          test_ending,
    output logic                          test_has_ended,
    output logic [DROP_CNT_W-1:0]         drop_cnt,
    output logic                          overflow
);
    localparam int unsigned BUF_W = 2 * ATOMS_PER_WORD;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ATOMS_PER_WORD);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_ENDED = 2'd2;

    logic [1:0]             state;
    logic [1:0]             state_next;
    logic                   flush_pend;
    logic                   flush_pend_next;
    logic                   out_valid;
    logic [CNT_W+BUF_W-1:0] out_word;

    logic hold_free;
    logic word_full;
    logic buf_empty;
    logic move;
    logic accept;
    logic drop;
    logic atom_ready_c;

    assign bus.out_valid  = out_valid;
    assign bus.out_word   = out_word;
    assign bus.atom_ready = atom_ready_c;

    // Hold-register availability, word hand-off and atom acceptance.
    always_comb begin
        hold_free       = !out_valid || bus.out_ready;
        word_full       = (dct_count == FULL_CNT);
        buf_empty       = (dct_count == '0);
        move            = hold_free && (word_full || (flush_pend && !buf_empty));
        // Gated by reset so the ready output is also low while reset is held.
        atom_ready_c    = reset_n && (state == ST_RUN) && (!word_full || move);
        accept          = bus.atom_valid && atom_ready_c;
        drop            = (state == ST_RUN) && bus.atom_valid && !atom_ready_c;
        // A pending flush on an empty buffer with nothing arriving has nothing to emit.
        flush_pend_next = (flush_pend || bus.flush || bus.end_req) && !move
                          && !(buf_empty && !accept);
    end

    // Run / drain / ended sequencing.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (bus.end_req) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (buf_empty && !flush_pend && hold_free) begin
                    state_next = ST_ENDED;
                end
            end
            ST_ENDED: begin
                state_next = ST_ENDED;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Monitor status flags, registered from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            test_ending    <= 1'b0;
            test_has_ended <= 1'b0;
        end else begin
            test_ending    <= (state_next == ST_DRAIN);
            test_has_ended <= (state_next == ST_ENDED);
        end
    end

    // Packing buffer and output hold register; an atom accepted on a move
    // cycle starts the next word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dct_buffer <= '0;
            dct_count  <= '0;
            out_valid  <= 1'b0;
            out_word   <= '0;
            flush_pend <= 1'b0;
        end else begin
            flush_pend <= flush_pend_next;
            if (move) begin
                out_word  <= {dct_count, dct_buffer};
                out_valid <= 1'b1;
                if (accept) begin
                    dct_buffer <= BUF_W'(bus.atom);
                    dct_count  <= CNT_W'(1);
                end else begin
                    dct_buffer <= '0;
                    dct_count  <= '0;
                end
            end else begin
                if (out_valid && bus.out_ready) begin
                    out_valid <= 1'b0;
                end
                if (accept) begin
                    dct_buffer <= {dct_buffer[BUF_W-3:0], bus.atom};
                    dct_count  <= dct_count + CNT_W'(1);
                end
            end
        end
    end

    // Saturating count of atoms refused while running.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_led_sopc_nios2_qsys_oci_dct_packer.sv
// Scenario bench for the OCI trace atom packer with a queue-based reference model.
module tb_led_sopc_nios2_qsys_oci_dct_packer;
    logic        clk;
    logic        reset_n;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_ending;
    logic        test_has_ended;
    logic [7:0]  drop_cnt;
    logic        overflow;

    int n_vec = 0;
    int n_bad = 0;

    led_sopc_nios2_qsys_oci_dct_packer_if bus ();

    led_sopc_nios2_qsys_oci_dct_packer #(
        .ATOMS_PER_WORD(15),
        .DROP_CNT_W    (8)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus           (bus),
        .dct_buffer    (dct_buffer),
        .dct_count     (dct_count),
        .test_ending   (test_ending),
        .test_has_ended(test_has_ended),
        .drop_cnt      (drop_cnt),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: atoms waiting in the current word, the held word,
    // pending flush, phase (0 run, 1 drain, 2 ended) and drop bookkeeping.
    int          mq[$];
    bit          m_valid;
    logic [33:0] m_word;
    bit          m_fp;
    int          m_st;
    int          m_drop;
    bit          m_ovf;
    logic        dut_rdy;
    bit          exp_rdy;

    function automatic logic [29:0] pack(input int q[$]);
        longint v = 0;
        foreach (q[i]) v = v * 4 + longint'(q[i]);
        return 30'(v);
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_valid = 0;
        m_word  = '0;
        m_fp    = 0;
        m_st    = 0;
        m_drop  = 0;
        m_ovf   = 0;
    endfunction

    function automatic bit m_ready(input bit ordy);
        int n = mq.size();
        bit mv = (!m_valid || ordy) && (n == 15 || (m_fp && n != 0));
        return (m_st == 0) && (n != 15 || mv);
    endfunction

    function automatic void model_clock(input bit av, input logic [1:0] a,
                                        input bit fl, input bit er, input bit ordy);
        int n    = mq.size();
        bit hf   = !m_valid || ordy;
        bit mv   = hf && (n == 15 || (m_fp && n != 0));
        bit rdy  = (m_st == 0) && (n != 15 || mv);
        bit acc  = av && rdy;
        int st_n = m_st;
        if (m_st == 0 && er) st_n = 1;
        else if (m_st == 1 && n == 0 && !m_fp && hf) st_n = 2;
        if (m_st == 0 && av && !rdy) begin
            m_ovf = 1;
            if (m_drop < 255) m_drop++;
        end
        m_fp = (m_fp || fl || er) && !mv && !(n == 0 && !acc);
        if (mv) begin
            m_word  = {4'(n), pack(mq)};
            m_valid = 1;
            mq.delete();
        end else if (m_valid && ordy) begin
            m_valid = 0;
        end
        if (acc) mq.push_back(int'(a));
        m_st = st_n;
    endfunction

    // One clock: drive at the falling edge, note ready, update model at the rising edge.
    task automatic cyc(input bit av, input logic [1:0] a, input bit fl, input bit er, input bit ordy);
        @(negedge clk);
        bus.atom_valid = av;
        bus.atom       = a;
        bus.flush      = fl;
        bus.end_req    = er;
        bus.out_ready  = ordy;
        #1;
        dut_rdy = bus.atom_ready;
        exp_rdy = m_ready(ordy);
        @(posedge clk);
        model_clock(av, a, fl, er, ordy);
        #1;
    endtask

    task automatic apply_reset();
        bus.atom_valid = 1'b0;
        bus.atom       = 2'd0;
        bus.flush      = 1'b0;
        bus.end_req    = 1'b0;
        bus.out_ready  = 1'b0;
        reset_n        = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.atom_valid = 1'b0;
        bus.atom       = 2'd0;
        bus.flush      = 1'b0;
        bus.end_req    = 1'b0;
        bus.out_ready  = 1'b0;
        reset_n        = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if ({bus.out_valid, bus.out_word} !== 35'd0) begin n_bad++; $display("FAIL reset_out: got %h want 0", {bus.out_valid, bus.out_word}); end
        n_vec++; if ({dct_buffer, dct_count} !== 34'd0) begin n_bad++; $display("FAIL reset_buf: got %h want 0", {dct_buffer, dct_count}); end
        n_vec++; if ({test_ending, test_has_ended, drop_cnt, overflow, bus.atom_ready} !== 12'd0) begin n_bad++; $display("FAIL reset_flags: got %h want 0", {test_ending, test_has_ended, drop_cnt, overflow, bus.atom_ready}); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_full_word();
        logic [33:0] exp = {4'hF, 30'h15555555};
        for (int i = 0; i < 15; i++) cyc(1, 2'b01, 0, 0, 1);
        n_vec++; if (dut_rdy !== 1'b1) begin n_bad++; $display("FAIL full_ready15: got %b want 1", dut_rdy); end
        n_vec++; if (dct_count !== 4'd15) begin n_bad++; $display("FAIL full_count15: got %0d want 15", dct_count); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL full_early_valid: got %b want 0", bus.out_valid); end
        cyc(0, 2'd0, 0, 0, 1);
        n_vec++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL full_valid: got %b want 1", bus.out_valid); end
        n_vec++; if (bus.out_word !== exp) begin n_bad++; $display("FAIL full_word: got %h want %h", bus.out_word, exp); end
        n_vec++; if (dct_count !== 4'd0) begin n_bad++; $display("FAIL full_count0: got %0d want 0", dct_count); end
        cyc(0, 2'd0, 0, 0, 1);
        n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL full_taken: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        logic [33:0] exp = {4'd3, 30'h00000039};
        cyc(1, 2'd3, 0, 0, 1);
        cyc(1, 2'd2, 0, 0, 1);
        cyc(1, 2'd1, 0, 0, 1);
        cyc(0, 2'd0, 1, 0, 1);
        n_vec++; if (bus.out_valid !== 1'b0 || dct_count !== 4'd3) begin n_bad++; $display("FAIL flush_pending: got valid %b count %0d want 0/3", bus.out_valid, dct_count); end
        cyc(1, 2'd2, 0, 0, 1);
        n_vec++; if (bus.out_word !== exp || bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL flush_word: got %b/%h want 1/%h", bus.out_valid, bus.out_word, exp); end
        n_vec++; if (dct_count !== 4'd1 || dct_buffer !== 30'd2) begin n_bad++; $display("FAIL flush_next: got %0d/%h want 1/2", dct_count, dct_buffer); end
        cyc(0, 2'd0, 1, 0, 1);
        cyc(0, 2'd0, 0, 0, 1);
        n_vec++; if (bus.out_word !== {4'd1, 30'd2}) begin n_bad++; $display("FAIL flush_single: got %h want %h", bus.out_word, {4'd1, 30'd2}); end
        cyc(0, 2'd0, 0, 0, 1);
    endtask

    task automatic test_backpressure();
        int          w1q[$];
        int          w2q[$];
        logic [1:0]  a;
        logic [33:0] w1;
        logic [33:0] w2;
        for (int i = 0; i < 30; i++) begin
            a = 2'($urandom);
            if (i < 15) w1q.push_back(int'(a)); else w2q.push_back(int'(a));
            cyc(1, a, 0, 0, 0);
            n_vec++; if (dut_rdy !== 1'b1) begin n_bad++; $display("FAIL bp_ready atom %0d: got %b want 1", i, dut_rdy); end
        end
        w1 = {4'd15, pack(w1q)};
        w2 = {4'd15, pack(w2q)};
        n_vec++; if (dct_count !== 4'd15 || bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_full: got count %0d valid %b want 15/1", dct_count, bus.out_valid); end
        for (int k = 0; k < 4; k++) begin
            cyc(1, 2'($urandom), 0, 0, 0);
            n_vec++; if (dut_rdy !== 1'b0) begin n_bad++; $display("FAIL bp_stall %0d: got %b want 0", k, dut_rdy); end
            n_vec++; if (bus.out_word !== w1) begin n_bad++; $display("FAIL bp_stable %0d: got %h want %h", k, bus.out_word, w1); end
        end
        n_vec++; if (drop_cnt !== 8'd4 || overflow !== 1'b1) begin n_bad++; $display("FAIL bp_drops: got %0d/%b want 4/1", drop_cnt, overflow); end
        cyc(0, 2'd0, 0, 0, 1);
        n_vec++; if (bus.out_word !== w2 || bus.out_valid !== 1'b1 || dct_count !== 4'd0) begin n_bad++; $display("FAIL bp_word2: got %h/%b/%0d want %h/1/0", bus.out_word, bus.out_valid, dct_count, w2); end
        cyc(0, 2'd0, 0, 0, 1);
        n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_random();
        bit         av;
        bit         fl;
        bit         ordy;
        logic [1:0] a;
        for (int c = 0; c < 300; c++) begin
            av   = ($urandom_range(9) < 7);
            a    = 2'($urandom);
            fl   = ($urandom_range(19) == 0);
            ordy = ($urandom_range(9) < 6);
            cyc(av, a, fl, 0, ordy);
            n_vec++; if (dut_rdy !== exp_rdy) begin n_bad++; $display("FAIL rnd_ready c%0d: got %b want %b", c, dut_rdy, exp_rdy); end
            n_vec++; if (dct_count !== 4'(mq.size()) || dct_buffer !== pack(mq)) begin n_bad++; $display("FAIL rnd_buf c%0d: got %0d/%h want %0d/%h", c, dct_count, dct_buffer, mq.size(), pack(mq)); end
            n_vec++; if (bus.out_valid !== m_valid || (m_valid && bus.out_word !== m_word)) begin n_bad++; $display("FAIL rnd_out c%0d: got %b/%h want %b/%h", c, bus.out_valid, bus.out_word, m_valid, m_word); end
            n_vec++; if (drop_cnt !== 8'(m_drop) || overflow !== m_ovf) begin n_bad++; $display("FAIL rnd_drop c%0d: got %0d/%b want %0d/%b", c, drop_cnt, overflow, m_drop, m_ovf); end
        end
    endtask

    task automatic test_reset_mid_word();
        apply_reset();
        for (int i = 0; i < 15; i++) cyc(1, 2'($urandom), 0, 0, 0);
        cyc(0, 2'd0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc(1, 2'($urandom), 0, 0, 0);
        n_vec++; if (dct_count !== 4'd7 || bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_setup: got %0d/%b want 7/1", dct_count, bus.out_valid); end
        bus.atom_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        n_vec++; if ({bus.out_valid, bus.out_word, dct_buffer, dct_count} !== 69'd0) begin n_bad++; $display("FAIL mid_async_data: got %h want 0", {bus.out_valid, bus.out_word, dct_buffer, dct_count}); end
        n_vec++; if ({bus.atom_ready, drop_cnt, overflow, test_ending, test_has_ended} !== 12'd0) begin n_bad++; $display("FAIL mid_async_flags: got %h want 0", {bus.atom_ready, drop_cnt, overflow, test_ending, test_has_ended}); end
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1, 2'd3, 0, 0, 1);
        cyc(0, 2'd0, 1, 0, 1);
        cyc(0, 2'd0, 0, 0, 1);
        n_vec++; if (bus.out_valid !== 1'b1 || bus.out_word !== {4'd1, 30'd3}) begin n_bad++; $display("FAIL mid_after: got %b/%h want 1/%h", bus.out_valid, bus.out_word, {4'd1, 30'd3}); end
        cyc(0, 2'd0, 0, 0, 1);
    endtask

    task automatic test_end_drain();
        int          q5[$];
        logic [1:0]  a;
        logic [33:0] exp;
        for (int i = 0; i < 5; i++) begin
            a = 2'($urandom);
            q5.push_back(int'(a));
            cyc(1, a, 0, 0, 1);
        end
        exp = {4'd5, pack(q5)};
        cyc(0, 2'd0, 0, 1, 1);
        n_vec++; if (test_ending !== 1'b1 || test_has_ended !== 1'b0 || bus.atom_ready !== 1'b0) begin n_bad++; $display("FAIL end_enter: got ending %b ended %b ready %b want 1/0/0", test_ending, test_has_ended, bus.atom_ready); end
        cyc(1, 2'd1, 0, 0, 1);
        n_vec++; if (dut_rdy !== 1'b0) begin n_bad++; $display("FAIL end_ready: got %b want 0", dut_rdy); end
        n_vec++; if (bus.out_valid !== 1'b1 || bus.out_word !== exp) begin n_bad++; $display("FAIL end_word: got %b/%h want 1/%h", bus.out_valid, bus.out_word, exp); end
        cyc(1, 2'd2, 0, 0, 1);
        n_vec++; if (test_has_ended !== 1'b1 || test_ending !== 1'b0 || bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL end_done: got ended %b ending %b valid %b want 1/0/0", test_has_ended, test_ending, bus.out_valid); end
        repeat (3) cyc(1, 2'($urandom), 0, 0, 1);
        n_vec++; if (drop_cnt !== 8'd0 || dct_count !== 4'd0 || test_has_ended !== 1'b1) begin n_bad++; $display("FAIL end_ignore: got drops %0d count %0d ended %b want 0/0/1", drop_cnt, dct_count, test_has_ended); end
    endtask

    task automatic test_end_empty();
        apply_reset();
        cyc(0, 2'd0, 1, 1, 1);
        n_vec++; if (test_ending !== 1'b1 || test_has_ended !== 1'b0) begin n_bad++; $display("FAIL empty_drain: got %b/%b want 1/0", test_ending, test_has_ended); end
        cyc(0, 2'd0, 0, 0, 1);
        n_vec++; if (test_has_ended !== 1'b1 || test_ending !== 1'b0 || bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL empty_ended: got %b/%b/%b want 1/0/0", test_has_ended, test_ending, bus.out_valid); end
    endtask

    task automatic test_drop_saturate();
        apply_reset();
        for (int i = 0; i < 15; i++) cyc(1, 2'($urandom), 0, 0, 0);
        cyc(0, 2'd0, 0, 0, 0);
        for (int i = 0; i < 15; i++) cyc(1, 2'($urandom), 0, 0, 0);
        for (int i = 0; i < 254; i++) cyc(1, 2'($urandom), 0, 0, 0);
        n_vec++; if (drop_cnt !== 8'd254) begin n_bad++; $display("FAIL sat_254: got %0d want 254", drop_cnt); end
        for (int i = 0; i < 46; i++) cyc(1, 2'($urandom), 0, 0, 0);
        n_vec++; if (drop_cnt !== 8'd255 || overflow !== 1'b1 || dut_rdy !== 1'b0) begin n_bad++; $display("FAIL sat_255: got %0d/%b/%b want 255/1/0", drop_cnt, overflow, dut_rdy); end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_flush();
        test_backpressure();
        test_random();
        test_reset_mid_word();
        test_end_drain();
        test_end_empty();
        test_drop_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/led_sopc_nios2_qsys_oci_dct_packer.md
Name: led_sopc_nios2_qsys_oci_dct_packer

Overview:
- Upstream stage of the OCI trace test-bench monitor.
- Packs 2-bit trace atoms into a 30-bit compression buffer (15 atoms max) and hands completed or flushed words to the trace sink through a valid/ready handshake.
- Drives dct_buffer, dct_count, test_ending and test_has_ended for the test-bench monitor.
- Sequences end-of-test drain and counts atoms dropped under back-pressure.

Parameters:
- ATOMS_PER_WORD, 15, atoms per full word; fixed so that 2*ATOMS_PER_WORD = 30.
- DROP_CNT_W, 8, width of the saturating dropped-atom counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- atom_valid  in  1  a trace atom is presented.
- atom  in  2  trace atom payload.
- atom_ready  out  1  packer accepts the atom this cycle (combinational).
- flush  in  1  single-cycle request to emit a partial word.
- end_req  in  1  single-cycle request to finish the test.
- out_valid  out  1  out_word holds a word.
- out_ready  in  1  sink accepts out_word.
- out_word  out  34  {count[3:0], buffer[29:0]} of the emitted word.
- dct_buffer  out  30  live packing buffer.
- dct_count  out  4  atoms currently in dct_buffer (0..15).
- test_ending  out  1  drain in progress.
- test_has_ended  out  1  drain complete (sticky).
- drop_cnt  out  DROP_CNT_W  saturating count of dropped atoms.
- overflow  out  1  sticky: at least one atom was dropped.

Behaviour:
- Reset values (asynchronous, while reset_n=0): every output 0, flush_pend=0, state=RUN. Reset asserted mid-word discards the partial buffer and any held out_word.
- Derived signals:
  - hold_free = !out_valid || out_ready
  - move = hold_free && (dct_count==15 || (flush_pend && dct_count!=0))
  - accept = atom_valid && atom_ready
  - atom_ready = (state==RUN) && (dct_count!=15 || move)
- On move:
  - out_word <= {dct_count, dct_buffer}; out_valid <= 1.
  - If accept in the same cycle: buffer <= {28'b0, atom} and count <= 1. Otherwise buffer <= 0 and count <= 0.
- Else if accept: dct_buffer <= {dct_buffer[27:0], atom}; dct_count <= dct_count+1. The oldest atom sits in the most significant occupied bits.
- Output handshake:
  - If out_valid && out_ready && !move: out_valid <= 0.
  - out_word is stable while out_valid=1 and out_ready=0.
- Latency: a full word appears on out_word 1 cycle after dct_count reaches 15, provided the hold register is free.
- Flush:
  - flush_pend <= (flush_pend || flush || end_req) && !move.
  - flush_pend clears without output when dct_count==0 and there is no accept.
  - An atom accepted in the move cycle belongs to the next word.
- Drops: atom_valid && !atom_ready while state==RUN increments drop_cnt (saturates at all-ones) and sets overflow. Atoms presented outside RUN are ignored and not counted.
- State machine:
  - RUN: end_req -> DRAIN (flush_pend is set by the same edge).
  - DRAIN: test_ending=1, atom_ready=0. Exit to ENDED when dct_count==0 && !flush_pend && (!out_valid || out_ready).
  - ENDED: test_ending=0, test_has_ended=1. Held until reset.
- end_req with an empty buffer and no held word reaches ENDED 1 cycle after DRAIN entry.
- flush together with end_req behaves as end_req alone.
- dct_count never exceeds 15; dct_buffer bits above 2*dct_count are always 0.

Test Plan:
- Reset, then 15 atoms 2'b01 back-to-back with out_ready=1 -> 1 cycle after the 15th accept: out_valid=1, out_word={4'hF, 30'h15555555}; dct_count=0.
- 3 atoms 3,2,1 then a flush pulse -> out_word={4'd3, 30'h00000039}; a 4th atom sent in the move cycle leaves dct_count=1.
- out_ready=0; fill two full words with a continuous atom stream -> atom_ready drops at the 15th atom of word 2; 4 extra atoms give drop_cnt=4 and overflow=1; the first word stays stable until out_ready=1.
- 5 atoms then end_req with out_ready=1 -> test_ending=1, atom_ready=0, one word with count 5; test_has_ended=1 the cycle after it is taken; later atoms are not counted.
- Assert reset_n=0 mid-word (dct_count=7, out_valid=1) -> all outputs 0 immediately, without waiting for a clock; after release, a 1-atom flush yields count 1.
- Drive 300 drops -> drop_cnt saturates at 255.
